// File: rtl/iterative_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter, up to STEP bits per clock, valid/ready in and out.
// Optional SHIFT_STATUS_EN adds out_carry (last bit shifted out) and out_zero.
module iterative_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
`ifdef SHIFT_STATUS_EN
   ,output logic               out_carry,
    output logic               out_zero
`endif
);

    localparam logic [SHAMT_W:0] STEP_K  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_K = (SHAMT_W+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic [SHAMT_W:0]   k;
    logic [WIDTH-1:0]   shifted;

`ifdef SHIFT_STATUS_EN
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   lsl_out;
    logic [WIDTH-1:0]   rsh_out;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        mode_d  = mode_q;
        // Never shift further than what remains of the request
        k = ({1'b0, count_q} < STEP_K) ? {1'b0, count_q} : STEP_K;
        unique case (mode_q)
            2'b00:   shifted = data_q << k;
            2'b01:   shifted = data_q >> k;
            2'b10:   shifted = WIDTH'($signed(data_q) >>> k);
            default: shifted = (data_q >> k) | (data_q << (WIDTH_K - k));
        endcase
`ifdef SHIFT_STATUS_EN
        carry_d = carry_q;
        lsl_out = data_q >> (WIDTH_K - k);
        rsh_out = data_q >> (k - 1'b1);
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    count_d = in_shamt;
                    mode_d  = in_mode;
`ifdef SHIFT_STATUS_EN
                    carry_d = 1'b0;
`endif
                    state_d = (in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d  = shifted;
                count_d = count_q - k[SHAMT_W-1:0];
`ifdef SHIFT_STATUS_EN
                carry_d = (mode_q == 2'b00) ? lsl_out[0] : rsh_out[0];
`endif
                if (count_d == '0) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

`ifdef SHIFT_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) carry_q <= 1'b0;
        else        carry_q <= carry_d;
    end

    assign out_carry = (state_q == DONE) & carry_q;
    assign out_zero  = (state_q == DONE) & (data_q == '0);
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Bench for iterative_shift_unit: STEP=1 and STEP=4 instances against a
// plain-arithmetic shift model, directed table plus random and corner sequences.
module tb_iterative_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [4:0]  in_shamt  [2];
    logic [1:0]  in_mode   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        busy      [2];
`ifdef SHIFT_STATUS_EN
    logic        out_carry [2];
    logic        out_zero  [2];
`endif

    int steps [2] = '{1, 4};
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    iterative_shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_shamt(in_shamt[0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0])
`ifdef SHIFT_STATUS_EN
       ,.out_carry(out_carry[0]), .out_zero(out_zero[0])
`endif
    );

    iterative_shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_shamt(in_shamt[1]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1])
`ifdef SHIFT_STATUS_EN
       ,.out_carry(out_carry[1]), .out_zero(out_zero[1])
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  sh;
        logic [1:0]  m;
        logic [31:0] exp;
        logic        c;
        int          hold;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: one-shot shift by the full amount
    function automatic logic [31:0] ref_res(logic [31:0] d, int sh,
                                            logic [1:0] m);
        logic [63:0] w;
        case (m)
            2'd0: return d << sh;
            2'd1: return d >> sh;
            2'd2: begin w = {{32{d[31]}}, d}; w = w >> sh; return w[31:0]; end
            default: begin w = {d, d}; w = w >> sh; return w[31:0]; end
        endcase
    endfunction

    function automatic logic ref_carry(logic [31:0] d, int sh, logic [1:0] m);
        if (sh == 0) return 1'b0;
        if (m == 2'd0) return d[32-sh];
        return d[sh-1];
    endfunction

    task automatic do_op(input int u, input string nm, input logic [31:0] d,
                         input logic [4:0] sh, input logic [1:0] m,
                         input logic [31:0] exp, input logic c, input int hold);
        int lat, n, elat;
        logic st;
        logic [31:0] first;
        @(negedge clk);
        n = 0;
        while (!in_ready[u] && n < 50) begin @(negedge clk); n++; end
        chk({nm, " in_ready"}, 32'(in_ready[u]), 32'd1);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_shamt[u] = sh;
        in_mode[u]  = m;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        in_data[u]  = $urandom;
        in_shamt[u] = 5'($urandom);
        in_mode[u]  = 2'($urandom);
        lat = 1;
        st = 1'b1;
        while (!out_valid[u] && lat < 100) begin
            if (!busy[u] || in_ready[u]) st = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        elat = (int'(sh) + steps[u] - 1) / steps[u] + 1;
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " busy"}, 32'(st & busy[u] & !in_ready[u]), 32'd1);
        first = out_data[u];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, " hold"}, {out_data[u][31:2], out_valid[u], in_ready[u]},
                {first[31:2], 2'b10});
        end
        out_ready[u] = 1'b1;
        chk({nm, " data"}, out_data[u], exp);
`ifdef SHIFT_STATUS_EN
        chk({nm, " carry"}, 32'(out_carry[u]), 32'(c));
        chk({nm, " zero"}, 32'(out_zero[u]), 32'(exp == 32'd0));
`else
        if (c === 1'bx) $display("unused carry for %s", nm);
`endif
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        chk({nm, " release"}, {31'd0, out_valid[u]}, 32'd0);
        chk({nm, " ready again"}, 32'(in_ready[u]), 32'd1);
    endtask

    task automatic b2b(input int u);
        int c, a1, a2, n;
        @(negedge clk);
        out_ready[u] = 1'b1;
        in_valid[u]  = 1'b1;
        in_data[u]   = 32'h3;
        in_shamt[u]  = 5'd3;
        in_mode[u]   = 2'd0;
        a1 = -1;
        a2 = -1;
        c = 0;
        while (a2 < 0 && c < 60) begin
            if (in_ready[u]) begin
                if (a1 < 0) a1 = c;
                else a2 = c;
            end
            @(posedge clk); #1;
            if (a1 == c) in_shamt[u] = 5'd5;
            @(negedge clk);
            c++;
        end
        in_valid[u] = 1'b0;
        chk("b2b period", 32'(a2 - a1), 32'((3 + steps[u] - 1) / steps[u] + 2));
        n = 0;
        while (!in_ready[u] && n < 60) begin @(negedge clk); n++; end
        chk("b2b drain", 32'(in_ready[u]), 32'd1);
        out_ready[u] = 1'b0;
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{32'h0000_0001, 5'd4,  2'd0, 32'h0000_0010, 1'b0, 0};
        tbl[1]  = '{32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF, 1'b0, 0};
        tbl[2]  = '{32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001, 1'b0, 0};
        tbl[3]  = '{32'h0000_00F1, 5'd4,  2'd3, 32'h1000_000F, 1'b0, 1};
        tbl[4]  = '{32'hDEAD_BEEF, 5'd0,  2'd2, 32'hDEAD_BEEF, 1'b0, 3};
        tbl[5]  = '{32'h0000_0001, 5'd7,  2'd0, 32'h0000_0080, 1'b0, 0};
        tbl[6]  = '{32'h0000_0001, 5'd31, 2'd3, 32'h0000_0002, 1'b0, 0};
        tbl[7]  = '{32'h8000_0001, 5'd1,  2'd0, 32'h0000_0002, 1'b1, 0};
        tbl[8]  = '{32'h0000_0001, 5'd1,  2'd1, 32'h0000_0000, 1'b1, 0};
        tbl[9]  = '{32'hF000_0000, 5'd28, 2'd1, 32'h0000_000F, 1'b0, 2};
        tbl[10] = '{32'hFFFF_FFFF, 5'd31, 2'd0, 32'h8000_0000, 1'b1, 0};
        tbl[11] = '{32'h1234_5678, 5'd0,  2'd3, 32'h1234_5678, 1'b0, 0};
        tbl[12] = '{32'h7FFF_FFFF, 5'd31, 2'd2, 32'h0000_0000, 1'b1, 0};

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; out_ready[u] = 1'b0;
            in_data[u] = '0; in_shamt[u] = '0; in_mode[u] = '0;
        end
        #22;
        for (int u = 0; u < 2; u++) begin
            chk("reset in_ready", 32'(in_ready[u]), 32'd1);
            chk("reset out_valid", 32'(out_valid[u]), 32'd0);
            chk("reset out_data", out_data[u], 32'd0);
            chk("reset busy", 32'(busy[u]), 32'd0);
`ifdef SHIFT_STATUS_EN
            chk("reset status", {out_carry[u], out_zero[u]}, 32'd0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 13; i++)
                do_op(u, $sformatf("vec%0d/u%0d", i, u), tbl[i].d, tbl[i].sh,
                      tbl[i].m, tbl[i].exp, tbl[i].c, tbl[i].hold);

        // Abort mid-SHIFT: reset must clear everything with no result
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h1;
        in_shamt[0] = 5'd20;
        in_mode[0]  = 2'd0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid[0]), 32'd0);
        chk("abort out_data", out_data[0], 32'd0);
        chk("abort in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, "post-abort", 32'hF000_0000, 5'd28, 2'd1, 32'h0000_000F,
              1'b0, 0);

        b2b(0);
        b2b(1);

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 30; i++) begin
                logic [31:0] d;
                logic [4:0]  sh;
                logic [1:0]  m;
                d  = $urandom;
                sh = 5'($urandom_range(0, 31));
                m  = 2'($urandom_range(0, 3));
                do_op(u, $sformatf("rnd%0d/u%0d", i, u), d, sh, m,
                      ref_res(d, int'(sh), m), ref_carry(d, int'(sh), m),
                      int'($urandom_range(0, 2)));
            end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iterative_shift_unit.md
Name: iterative_shift_unit

Overview:
Multi-cycle, parametrised shifter. It is the successor to the single-bit, single-mode, combinational shift block. It accepts one operand plus shift amount and mode over a valid/ready handshake, then shifts up to STEP bits per clock until the requested amount is done. It returns the result over a second valid/ready handshake and sits between the operand register file and the ALU result mux.

Parameters:
WIDTH, 32, operand width; power of two, >= 4
STEP, 1, max bits shifted per clock; power of two, 1 <= STEP <= WIDTH
SHAMT_W, $clog2(WIDTH), localparam (derived, not overridable), shift-amount width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_data  input  WIDTH  operand
in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (rotate right)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low; deassertion is synchronised externally.
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0. Internal count=0, mode=00. in_ready=1, since it is decoded from state IDLE.
- FSM, IDLE:
  - in_ready=1.
  - Accept when in_valid & in_ready: latch data/shamt/mode.
  - shamt==0 -> DONE, otherwise -> SHIFT.
- FSM, SHIFT:
  - Each clock, k = min(STEP, count).
  - Shift the working register by k per mode; count -= k.
  - When the new count==0 -> DONE.
- FSM, DONE:
  - out_valid=1 and out_data = working register, both held stable until out_ready.
  - On out_valid & out_ready -> IDLE.
- No overlap: in_ready=0 in SHIFT and DONE. A new request is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid asserts ceil(shamt/STEP)+1 clocks after the accepting edge. shamt=0 gives 1 clock.
- Mode rules:
  - LSL fills with 0.
  - LSR fills with 0.
  - ASR fills with the operand MSB latched at accept.
  - ROR moves the bits shifted out of the LSB into the MSB.
- Result is identical to a one-shot shift by shamt for every STEP value.
- out_ready high while not in DONE: ignored. in_valid outside IDLE: ignored; the requester must hold the request until in_ready.
- in_data/in_shamt/in_mode changes after accept have no effect.
- Reset asserted mid-SHIFT or mid-DONE: the operation is aborted, everything returns to reset values immediately, and no partial result is emitted.
- Back-to-back: with out_ready held high, throughput is one result per ceil(shamt/STEP)+2 clocks.

Optional Feature:
Macro SHIFT_STATUS_EN.
- When defined, two extra outputs are added:
  - out_carry (1 bit): last bit shifted out. LSL: bit leaving the MSB. LSR/ASR/ROR: bit leaving the LSB. 0 when shamt=0.
  - out_zero (1 bit): out_data==0.
- Both are valid and held with out_valid, and are 0 in reset.
- When undefined, these ports and their logic do not exist; all other behaviour is unchanged.

Test Plan:
1. WIDTH=32, STEP=1: LSL 0x0000_0001 shamt 4 -> out_data 0x0000_0010; out_valid 5 clocks after accept; busy high throughout.
2. ASR 0x8000_0000 shamt 31 -> 0xFFFF_FFFF; LSR of the same operand -> 0x0000_0001; ROR 0x0000_00F1 shamt 4 -> 0x1000_000F.
3. shamt=0, any mode, data 0xDEAD_BEEF -> 0xDEAD_BEEF one clock after accept. Hold out_ready=0 for 3 clocks -> out_data stable, in_ready=0; accept occurs on the 4th clock.
4. Start LSL shamt 20, pull rst_n low at the 5th SHIFT clock -> out_valid=0, out_data=0, in_ready=1 immediately. After release, LSR 0xF000_0000 shamt 28 -> 0x0000_000F.
5. WIDTH=32, STEP=4: LSL 0x1 shamt 7 -> 0x80 after 2 SHIFT clocks (k=4 then 3), latency 3. ROR 0x1 shamt 31 -> 0x2.
6. SHIFT_STATUS_EN defined: LSL 0x8000_0001 shamt 1 -> out_data 0x2, out_carry=1, out_zero=0. LSR 0x1 shamt 1 -> out_data 0, out_carry=1, out_zero=1.
